// File: rtl/umtrx_tx_dac_gate.sv
// umtrx_tx_dac_gate: per-channel primed FIFO between the TX deframers and the DAC, one sample per dac_stb.
// Define UMTRX_TX_ROUND_EN for round-half-up with positive saturation; otherwise samples are truncated.
module umtrx_tx_dac_chan #(
  parameter int SW = 16,
  parameter int DW = 12,
  parameter int HD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          dac_stb,
  input  logic          in_valid,
  input  logic [2*SW-1:0] in_data,
  output logic          in_ready,
  output logic          run,
  output logic          underrun,
  output logic [DW-1:0] dac_i,
  output logic [DW-1:0] dac_q
);
  localparam int AW = $clog2(HD);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDER} state_t;

  state_t          state_q, state_d;
  logic [2*SW-1:0] mem_q [HD];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [DW-1:0]   dac_i_q, dac_i_d, dac_q_q, dac_q_d;
  logic            run_q, run_d, und_q, und_d;
  logic            push, pop, set_und, empty, full, primed;
  logic [1:0][SW-1:0] head;
  logic [1:0][DW-1:0] cvt;
  logic            unused_lsb;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(HD));
  assign primed   = (cnt_q >= (AW+1)'(HD/2));
  assign in_ready = en & ~full;
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rptr_q];
  assign unused_lsb = ^{head[1][SW-DW-1:0], head[0][SW-DW-1:0]};

  for (genvar k = 0; k < 2; k++) begin : g_cvt
`ifdef UMTRX_TX_ROUND_EN
    logic [DW-1:0] top;
    logic          rbit;
    assign top  = head[k][SW-1 -: DW];
    assign rbit = head[k][SW-DW-1];
    // Only the max positive code can carry out; it already equals the saturated value.
    assign cvt[k] = (top == {1'b0, {(DW-1){1'b1}}} && rbit) ? top : top + DW'(rbit);
`else
    assign cvt[k] = head[k][SW-1 -: DW];
`endif
  end

  always_comb begin
    state_d = state_q;
    dac_i_d = dac_i_q;
    dac_q_d = dac_q_q;
    pop     = 1'b0;
    set_und = 1'b0;
    case (state_q)
      IDLE: begin
        dac_i_d = '0;
        dac_q_d = '0;
        if (en) state_d = PRIME;
      end
      PRIME: begin
        dac_i_d = '0;
        dac_q_d = '0;
        if (primed) state_d = RUN;
      end
      RUN: begin
        if (dac_stb) begin
          if (!empty) begin
            pop     = 1'b1;
            dac_i_d = cvt[1];
            dac_q_d = cvt[0];
          end else begin
            dac_i_d = '0;
            dac_q_d = '0;
            set_und = 1'b1;
            state_d = UNDER;
          end
        end
      end
      UNDER: begin
        if (dac_stb) begin
          dac_i_d = '0;
          dac_q_d = '0;
        end
        if (primed) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      dac_i_d = '0;
      dac_q_d = '0;
      pop     = 1'b0;
      set_und = 1'b0;
    end
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // A disabled channel holds nothing, so the flush follows the enable bit directly.
    if (!en) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
    run_d = (state_q != IDLE);
    und_d = set_und | (und_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      dac_i_q <= '0;
      dac_q_q <= '0;
      run_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      dac_i_q <= dac_i_d;
      dac_q_q <= dac_q_d;
      run_q   <= run_d;
      und_q   <= und_d;
    end
  end

  assign dac_i    = dac_i_q;
  assign dac_q    = dac_q_q;
  assign run      = run_q;
  assign underrun = und_q;
endmodule

module umtrx_tx_dac_gate #(
  parameter int BASE         = 0,
  parameter int NCH          = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DAC_WIDTH    = 12,
  parameter int HOLD_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          set_stb,
  input  logic [7:0]                    set_addr,
  input  logic [31:0]                   set_data,
  input  logic [NCH*2*SAMPLE_WIDTH-1:0] sample_data,
  input  logic [NCH-1:0]                sample_valid,
  output logic [NCH-1:0]                sample_ready,
  input  logic                          dac_stb,
  output logic [NCH*DAC_WIDTH-1:0]      dac_i,
  output logic [NCH*DAC_WIDTH-1:0]      dac_q,
  output logic [NCH-1:0]                run,
  output logic [NCH-1:0]                underrun
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int DW = DAC_WIDTH;
  localparam logic [7:0] A_EN  = 8'(BASE);
  localparam logic [7:0] A_CLR = 8'(BASE + 1);

  logic [NCH-1:0] en_q, en_d, clr;
  logic           unused_set;

  assign unused_set = ^set_data[31:NCH];

  always_comb begin
    en_d = en_q;
    if (set_stb && set_addr == A_EN) en_d = set_data[NCH-1:0];
  end

  // Clear is a same-cycle pulse; a coincident underrun still sets the flag.
  assign clr = (set_stb && set_addr == A_CLR) ? set_data[NCH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) en_q <= '0;
    else        en_q <= en_d;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    umtrx_tx_dac_chan #(.SW(SW), .DW(DW), .HD(HOLD_DEPTH)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_q[ch]),
      .clr      (clr[ch]),
      .dac_stb  (dac_stb),
      .in_valid (sample_valid[ch]),
      .in_data  (sample_data[ch*2*SW +: 2*SW]),
      .in_ready (sample_ready[ch]),
      .run      (run[ch]),
      .underrun (underrun[ch]),
      .dac_i    (dac_i[ch*DW +: DW]),
      .dac_q    (dac_q[ch*DW +: DW])
    );
  end
endmodule
